// File: rtl/matricula_captura.sv
// Plate entry front end: assembles six keypad digits plus day of week and
// presents them to the plate checker under a valid/acknowledge handshake.
module matricula_captura #(
    parameter int unsigned DIGITS  = 6,
    parameter int unsigned TIMEOUT = 50
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  Digito,
    input  logic        DigVal,
    input  logic        Apagar,
    input  logic [2:0]  DiaIn,
    input  logic        MatAck,
    output logic [23:0] Matricula,
    output logic [2:0]  Dia,
    output logic        MatVal,
    output logic [2:0]  Contagem,
    output logic        Ocupado,
    output logic        Erro
);

    localparam int unsigned DW = 4;
    localparam int unsigned PW = DIGITS * DW;
    localparam int unsigned SW = PW - DW;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, RECV, HOLD} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   mat_q, mat_d;
    logic [2:0]      dia_q, dia_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            matval_q, matval_d;
    logic            ocup_q, ocup_d;
    logic            erro_q, erro_d;

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            timer_q  <= '0;
            mat_q    <= '0;
            dia_q    <= '0;
            cnt_q    <= '0;
            matval_q <= 1'b0;
            ocup_q   <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            timer_q  <= timer_d;
            mat_q    <= mat_d;
            dia_q    <= dia_d;
            cnt_q    <= cnt_d;
            matval_q <= matval_d;
            ocup_q   <= ocup_d;
            erro_q   <= erro_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        timer_d  = timer_q;
        mat_d    = mat_q;
        dia_d    = dia_q;
        cnt_d    = cnt_q;
        matval_d = matval_q;
        ocup_d   = ocup_q;
        erro_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!Apagar && DigVal) begin
                    shreg_d = SW'(Digito);
                    cnt_d   = 3'd1;
                    timer_d = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (Apagar) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    shreg_d = '0;
                    timer_d = '0;
                end else if (DigVal) begin
                    timer_d = '0;
                    if (cnt_q < 3'(DIGITS - 1)) begin
                        shreg_d = {shreg_q[SW-DW-1:0], Digito};
                        cnt_d   = cnt_q + 3'd1;
                    end else if (DiaIn == 3'd0) begin
                        erro_d  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end else begin
                        mat_d    = {shreg_q, Digito};
                        dia_d    = DiaIn;
                        matval_d = 1'b1;
                        ocup_d   = 1'b1;
                        cnt_d    = 3'(DIGITS);
                        state_d  = HOLD;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    erro_d  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    shreg_d = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HOLD: begin
                // Plate is frozen here; only the checker's acknowledge moves on
                if (MatAck) begin
                    matval_d = 1'b0;
                    ocup_d   = 1'b0;
                    cnt_d    = '0;
                    shreg_d  = '0;
                    timer_d  = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Matricula = mat_q;
    assign Dia       = dia_q;
    assign MatVal    = matval_q;
    assign Contagem  = cnt_q;
    assign Ocupado   = ocup_q;
    assign Erro      = erro_q;

endmodule
